// File: rtl/sha256_mem_responder.sv
// Memory-side responder for one SHA-256 engine: word RAM with 1-cycle reads,
// host preload/readback port and a job FSM that captures the 8-word digest.
// Optional: define SHA_MEM_WRITE_PROTECT_EN to restrict engine writes to the digest window.
module sha256_mem_responder #(
   parameter int          DEPTH       = 256,
   parameter logic [15:0] DIGEST_BASE = 16'h80,
   parameter int          TIMEOUT     = 4096
) (
   input  logic         clk,
   input  logic         reset_n,
   output logic         start,
   input  logic         done,
   input  logic         mem_we,
   input  logic [15:0]  mem_addr,
   input  logic [31:0]  mem_write_data,
   output logic [31:0]  mem_read_data,
   input  logic         host_go,
   input  logic         host_valid,
   output logic         host_ready,
   input  logic         host_we,
   input  logic [15:0]  host_addr,
   input  logic [31:0]  host_wdata,
   output logic [31:0]  host_rdata,
   output logic         host_rvalid,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         job_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_HOST = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   if (32'(DIGEST_BASE) + 32'd7 >= 32'(DEPTH)) begin : g_bad_base
      $error("DIGEST_BASE+7 must be below DEPTH");
   end
   if (DEPTH > 65536 || DEPTH < 8) begin : g_bad_depth
      $error("DEPTH must be within 8..65536");
   end

   logic [31:0]   ram_q [DEPTH];
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    wcnt_q, wcnt_d;
   logic [7:0]    mask_q, mask_d;
   logic [31:0]   dig_q [8];
   logic [31:0]   dig_d [8];
   logic          err_q, err_d;
   logic          dv_q, dv_d;
   logic          rdy_en_q;
   logic          rvalid_q;
   logic [31:0]   rdata_q, mrd_q;

   logic          host_acc, host_in, eng_in, eng_win, eng_own, eng_wr_ok, host_wr_ok;
   logic [15:0]   dig_off;

   assign host_in  = 32'(host_addr) < 32'(DEPTH);
   assign eng_in   = 32'(mem_addr) < 32'(DEPTH);
   assign dig_off  = mem_addr - DIGEST_BASE;
   assign eng_win  = dig_off < 16'd8;
   assign eng_own  = (state_q == S_RUN) || (state_q == S_FIN);

   // rdy_en_q keeps host_ready low while reset is held
   assign host_ready = host_valid && rdy_en_q && (state_q == S_HOST);
   assign host_acc   = host_ready;
   assign host_wr_ok = host_acc && host_we && host_in;
`ifdef SHA_MEM_WRITE_PROTECT_EN
   assign eng_wr_ok  = eng_own && mem_we && eng_in && eng_win;
`else
   assign eng_wr_ok  = eng_own && mem_we && eng_in;
`endif

   assign start         = (state_q == S_ARM);
   assign mem_read_data = mrd_q;
   assign host_rdata    = rdata_q;
   assign host_rvalid   = rvalid_q;
   assign digest_valid  = dv_q;
   assign job_err       = err_q;
   assign digest = {dig_q[0], dig_q[1], dig_q[2], dig_q[3],
                    dig_q[4], dig_q[5], dig_q[6], dig_q[7]};

   // Host and engine never write in the same state, so one write port suffices
   always_ff @(posedge clk) begin
      if (host_wr_ok)
         ram_q[host_addr[AW-1:0]] <= host_wdata;
      else if (eng_wr_ok)
         ram_q[mem_addr[AW-1:0]] <= mem_write_data;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      wcnt_d  = wcnt_q;
      mask_d  = mask_q;
      dig_d   = dig_q;
      err_d   = err_q;
      dv_d    = 1'b0;
      case (state_q)
         S_HOST: if (host_go) begin
            state_d = S_ARM;
            mask_d  = '0;
            err_d   = 1'b0;
         end
         S_ARM: begin
            state_d = S_WAIT;
            wcnt_d  = '0;
         end
         S_WAIT: begin
            if (!done) begin
               state_d = S_RUN;
               timer_d = '0;
            end else if (wcnt_q == 2'd3) begin
               err_d   = 1'b1;
               state_d = S_HOST;
            end else begin
               wcnt_d = wcnt_q + 2'd1;
            end
         end
         S_RUN: begin
            if (done) begin
               state_d = S_FIN;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_HOST;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_FIN:   state_d = S_HOST;
         default: state_d = S_HOST;
      endcase

      if (eng_own && mem_we && eng_win) begin
         dig_d[dig_off[2:0]]  = mem_write_data;
         mask_d[dig_off[2:0]] = 1'b1;
      end
      // A digest word written in the FIN cycle still counts
      if (state_q == S_FIN) begin
         if (&mask_d) dv_d = 1'b1;
         else         err_d = 1'b1;
      end

      if (state_q == S_RUN && !eng_in) err_d = 1'b1;
`ifdef SHA_MEM_WRITE_PROTECT_EN
      if (state_q == S_RUN && mem_we && eng_in && !eng_win) err_d = 1'b1;
`endif
      if (host_acc && !host_in) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_HOST;
         timer_q  <= '0;
         wcnt_q   <= '0;
         mask_q   <= '0;
         for (int i = 0; i < 8; i++) dig_q[i] <= '0;
         err_q    <= 1'b0;
         dv_q     <= 1'b0;
         rdy_en_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         mrd_q    <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         wcnt_q   <= wcnt_d;
         mask_q   <= mask_d;
         dig_q    <= dig_d;
         err_q    <= err_d;
         dv_q     <= dv_d;
         rdy_en_q <= 1'b1;
         rvalid_q <= host_acc && !host_we;
         mrd_q    <= eng_in ? ram_q[mem_addr[AW-1:0]] : '0;
         if (host_acc && !host_we)
            rdata_q <= host_in ? ram_q[host_addr[AW-1:0]] : '0;
      end
   end

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed bench for sha256_mem_responder: host access, digest jobs,
// missing-word, WAIT/RUN timeouts, message-area writes and mid-job reset.
module tb_sha256_mem_responder;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start, done, mem_we;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_write_data, mem_read_data;
   logic         host_go, host_valid, host_ready, host_we;
   logic [15:0]  host_addr;
   logic [31:0]  host_wdata, host_rdata;
   logic         host_rvalid;
   logic [255:0] digest;
   logic         digest_valid, job_err;

   int errors = 0;
   int checks = 0;

   localparam logic [255:0] EXP_DIG = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                       32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
`ifdef SHA_MEM_WRITE_PROTECT_EN
   localparam logic        EXP_A3_ERR = 1'b1;
   localparam logic [31:0] EXP_A3     = 32'h03030303;
`else
   localparam logic        EXP_A3_ERR = 1'b0;
   localparam logic [31:0] EXP_A3     = 32'h33333333;
`endif

   sha256_mem_responder dut (
      .clk(clk), .reset_n(reset_n), .start(start), .done(done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_read_data(mem_read_data), .host_go(host_go), .host_valid(host_valid),
      .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .digest(digest), .digest_valid(digest_valid), .job_err(job_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go_to_run();
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      done    = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      reset_n = 1'b0; done = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
      host_go = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = 16'd5; host_wdata = '0;
      #1;
      chk("rst_start", start, 1'b0);
      chk("rst_ready", host_ready, 1'b0);
      chk("rst_rvalid", host_rvalid, 1'b0);
      chk("rst_digest", digest, '0);
      chk("rst_dv", digest_valid, 1'b0);
      chk("rst_err", job_err, 1'b0);
      chk("rst_mrd", mem_read_data, '0);
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("ready_after_rst", host_ready, 1'b1);

      // host preload
      host_we = 1'b1; host_addr = 16'd5; host_wdata = 32'hDEADBEEF;
      tick();
      host_addr = 16'd3; host_wdata = 32'h03030303;
      tick();
      host_we = 1'b0; host_addr = 16'd5; mem_addr = 16'd5;
      tick();
      chk("host_rvalid", host_rvalid, 1'b1);
      chk("host_rdata5", host_rdata, 32'hDEADBEEF);
      chk("eng_rd5", mem_read_data, 32'hDEADBEEF);
      host_valid = 1'b0;
      tick();
      chk("rvalid_drop", host_rvalid, 1'b0);
      host_valid = 1'b1;

      // job 1: full digest
      host_go = 1'b1;
      tick();
      chk("arm_start", start, 1'b1);
      host_go = 1'b0;
      tick();
      chk("wait_start", start, 1'b0);
      done = 1'b0;
      tick();
      chk("run_ready", host_ready, 1'b0);
      host_go = 1'b1;
      mem_we = 1'b1; mem_addr = 16'h80; mem_write_data = 32'hAAAAAAAA;
      tick();
      mem_write_data = 32'h11111111;
      tick();
      chk("rbw_old", mem_read_data, 32'hAAAAAAAA);
      for (int i = 1; i < 8; i++) begin
         mem_addr = 16'h80 + 16'(i);
         mem_write_data = 32'h11111111 * 32'(i + 1);
         tick();
         chk("no_restart", start, 1'b0);
      end
      host_go = 1'b0; mem_we = 1'b0; done = 1'b1;
      tick();
      chk("fin_dv", digest_valid, 1'b0);
      tick();
      chk("job1_dv", digest_valid, 1'b1);
      chk("job1_digest", digest, EXP_DIG);
      chk("job1_err", job_err, 1'b0);
      chk("job1_ready", host_ready, 1'b1);
      tick();
      chk("dv_pulse", digest_valid, 1'b0);

      // job 2: h7 never written
      go_to_run();
      mem_we = 1'b1;
      for (int i = 0; i < 7; i++) begin
         mem_addr = 16'h80 + 16'(i);
         mem_write_data = 32'h01010101 * 32'(i + 1);
         tick();
      end
      mem_we = 1'b0; done = 1'b1;
      tick();
      tick();
      chk("miss_dv", digest_valid, 1'b0);
      chk("miss_err", job_err, 1'b1);
      chk("miss_ready", host_ready, 1'b1);

      // done never drops
      host_go = 1'b1;
      tick();
      chk("go_clr_err", job_err, 1'b0);
      host_go = 1'b0;
      tick();
      tick(); tick(); tick();
      chk("wait3_err", job_err, 1'b0);
      chk("wait3_ready", host_ready, 1'b0);
      tick();
      chk("wait_to_err", job_err, 1'b1);
      chk("wait_to_ready", host_ready, 1'b1);

      // done held low past TIMEOUT
      go_to_run();
      chk("run_err0", job_err, 1'b0);
      repeat (4095) tick();
      chk("run_pre_to_err", job_err, 1'b0);
      chk("run_pre_to_ready", host_ready, 1'b0);
      tick();
      chk("run_to_err", job_err, 1'b1);
      chk("run_to_ready", host_ready, 1'b1);
      done = 1'b1;

      // engine write into message area
      go_to_run();
      mem_we = 1'b1; mem_addr = 16'd3; mem_write_data = 32'h33333333;
      tick();
      for (int i = 0; i < 8; i++) begin
         mem_addr = 16'h80 + 16'(i);
         mem_write_data = 32'h11111111 * 32'(i + 1);
         tick();
      end
      mem_we = 1'b0; done = 1'b1;
      tick();
      tick();
      chk("a3_err", job_err, EXP_A3_ERR);
      chk("a3_dv", digest_valid, 1'b1);
      host_addr = 16'd3;
      tick();
      chk("a3_rdata", host_rdata, EXP_A3);
      host_addr = 16'd256;
      tick();
      chk("oor_rvalid", host_rvalid, 1'b1);
      chk("oor_rdata", host_rdata, '0);
      chk("oor_err", job_err, 1'b1);

      // reset mid-RUN
      host_addr = 16'd5;
      go_to_run();
      mem_addr = 16'd5;
      tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_start", start, 1'b0);
      chk("mid_rst_err", job_err, 1'b0);
      chk("mid_rst_digest", digest, '0);
      chk("mid_rst_ready", host_ready, 1'b0);
      chk("mid_rst_mrd", mem_read_data, '0);
      tick(); tick();
      reset_n = 1'b1; done = 1'b1;
      tick();
      chk("post_rst_ready", host_ready, 1'b1);
      chk("post_rst_start", start, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
